// File: rtl/uart_tx_io_if.sv
// Memory-mapped IO bus between the core's memory stage and the UART transmitter.
interface uart_tx_io_if;
    logic [31:0] IO_mem_addr;
    logic [31:0] IO_mem_wdata;
    logic        IO_mem_wr;
    logic [31:0] IO_mem_rdata;

    modport master (
        output IO_mem_addr,
        output IO_mem_wdata,
        output IO_mem_wr,
        input  IO_mem_rdata
    );

    modport slave (
        input  IO_mem_addr,
        input  IO_mem_wdata,
        input  IO_mem_wr,
        output IO_mem_rdata
    );
endinterface

// File: rtl/uart_tx_io.sv
// 8N1 UART transmitter behind a small write FIFO, with data/status and
// overflow-clear registers on the IO bus.
module uart_tx_io #(
    parameter int unsigned DIV   = 234,
    parameter int unsigned DEPTH = 16
) (
    input  logic         clk,
    input  logic         resetn,
    uart_tx_io_if.slave  io,
    output logic         tx
);
    localparam int unsigned   AW        = $clog2(DEPTH);
    localparam int unsigned   CW        = AW + 1;
    localparam logic [15:0]   BAUD_LAST = 16'(DIV - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state_q,  state_d;
    logic [15:0]   baud_q,   baud_d;
    logic [2:0]    bit_q,    bit_d;
    logic [7:0]    shift_q,  shift_d;
    logic          tx_q,     tx_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          ovf_q,    ovf_d;
    logic [7:0]    mem [DEPTH];

    logic sel_data_s;
    logic sel_ctrl_s;
    logic wr_data_s;
    logic full_s;
    logic busy_s;
    logic push_s;
    logic pop_s;
    logic baud_end_s;
    logic unused_s;

    assign sel_data_s = io.IO_mem_addr[3];
    assign sel_ctrl_s = io.IO_mem_addr[4] & ~io.IO_mem_addr[3];
    assign wr_data_s  = io.IO_mem_wr & sel_data_s;
    assign full_s     = (count_q == CNT_FULL);
    assign busy_s     = (state_q != IDLE) | (count_q != CNT_ZERO);
    // Acceptance is judged on the start-of-cycle count, so a same-cycle pop never rescues a write.
    assign push_s     = wr_data_s & ~full_s;
    assign baud_end_s = (baud_q == BAUD_LAST);
    assign unused_s   = ^{io.IO_mem_addr[31:5], io.IO_mem_addr[2:0], io.IO_mem_wdata[31:8]};
    assign tx         = tx_q;

    // Serial framing FSM: next state, baud/bit counters, shift register and line level.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop_s   = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = 16'd0;
                bit_d  = 3'd0;
                if (count_q != CNT_ZERO) begin
                    pop_s   = 1'b1;
                    shift_d = mem[rd_ptr_q];
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (baud_end_s) begin
                    baud_d  = 16'd0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            DATA: begin
                if (baud_end_s) begin
                    baud_d  = 16'd0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        bit_d   = 3'd0;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            STOP: begin
                if (baud_end_s) begin
                    baud_d = 16'd0;
                    if (count_q != CNT_ZERO) begin
                        pop_s   = 1'b1;
                        shift_d = mem[rd_ptr_q];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: begin
                baud_d  = 16'd0;
                bit_d   = 3'd0;
                state_d = IDLE;
            end
        endcase

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // FIFO bookkeeping and sticky overflow flag.
    always_comb begin
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (wr_data_s && full_s) begin
            ovf_d = 1'b1;
        end else if (io.IO_mem_wr && sel_ctrl_s) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Status read mux.
    always_comb begin
        if (sel_data_s) begin
            io.IO_mem_rdata = {23'd0, 6'(count_q), ovf_q, busy_s, full_s};
        end else begin
            io.IO_mem_rdata = 32'd0;
        end
    end

    // Control and datapath state registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            baud_q   <= 16'd0;
            bit_q    <= 3'd0;
            shift_q  <= 8'd0;
            tx_q     <= 1'b1;
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= CNT_ZERO;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // FIFO storage carries no reset; the pointers alone define its contents.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem[wr_ptr_q] <= io.IO_mem_wdata[7:0];
        end
    end
endmodule

// File: doc/uart_tx_io.md
UART_TX_IO -- requirements
Module: uart_tx_io

Interface
REQ-001 Parameter DIV, default 234, clk cycles per serial bit (27 MHz / 115200); legal range 2..65535.
REQ-002 Parameter DEPTH, default 16, TX FIFO entries; power of two, 2..64.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 IO_mem_addr  input  32  IO byte address from core memory stage; only bits [4:3] are decoded.
REQ-006 IO_mem_wdata  input  32  IO write data; only bits [7:0] are used.
REQ-007 IO_mem_wr  input  1  single-cycle IO write strobe, already qualified by the IO address space.
REQ-008 IO_mem_rdata  output  32  combinational read data for IO_mem_addr.
REQ-009 tx  output  1  serial line, idle high.

Function
REQ-010 The data register SHALL be selected when IO_mem_addr[3]=1; the control register SHALL be selected when IO_mem_addr[4]=1 and IO_mem_addr[3]=0.
REQ-011 A cycle with IO_mem_wr=1 and the data register selected SHALL push IO_mem_wdata[7:0] into the FIFO if count<DEPTH at the start of that cycle.
REQ-012 A data write while count==DEPTH SHALL be dropped and SHALL set sticky flag ovf, even if a pop occurs in the same cycle.
REQ-013 A cycle with IO_mem_wr=1 and the control register selected SHALL clear ovf; a set in the same cycle is impossible by decode.
REQ-014 With the data register selected, IO_mem_rdata SHALL be {23'b0, count[5:0] in bits [8:3], ovf in bit 2, busy in bit 1, full in bit 0}; count is zero-extended.
REQ-015 With the data register not selected, IO_mem_rdata SHALL be 0.
REQ-016 full = (count==DEPTH); busy = (state!=IDLE) or (count!=0).
REQ-017 The FIFO SHALL be circular with wrapping read and write pointers, and SHALL preserve write order.
REQ-018 A simultaneous push and pop SHALL leave count unchanged.
REQ-019 The FSM SHALL have states IDLE, START, DATA, STOP, with a baud counter running 0..DIV-1 and a bit index running 0..7.
REQ-020 In IDLE with count!=0, the FSM SHALL pop the head byte into the shift register and go to START on the same edge; tx SHALL go low from the next cycle.
REQ-021 START SHALL hold tx=0 for DIV cycles, then go to DATA.
REQ-022 DATA SHALL drive shift-register bit 0 (LSB first) for DIV cycles per bit, 8 bits, then go to STOP.
REQ-023 STOP SHALL hold tx=1 for DIV cycles; on its last cycle the FSM SHALL pop and go to START if count!=0, else go to IDLE.
REQ-024 Back-to-back frames SHALL have no idle gap; each frame SHALL be exactly 10*DIV cycles.
REQ-025 Latency: with the FSM in IDLE and the FIFO empty, a write at edge k SHALL pop at edge k+1 and drive tx=0 from edge k+1.
REQ-026 A byte in flight SHALL be unaffected by FIFO writes and by ovf clear.

Reset
REQ-027 While resetn=0: tx=1, state=IDLE, count=0, pointers=0, ovf=0, baud counter=0, bit index=0.
REQ-028 IO_mem_rdata SHALL read 0x0 status during reset.
REQ-029 Reset asserted mid-frame SHALL abort the frame and drive tx high immediately; FIFO contents SHALL be discarded.
REQ-030 FIFO storage SHALL not require reset.

Verification (DIV=4, DEPTH=4)
REQ-031 Reset release, no writes -> tx=1 continuously; status read at addr 0x400008 = 0x0.
REQ-032 Write 0xA5 to 0x400008 at edge k -> tx=0 over cycles k+1..k+4; then bits 1,0,1,0,0,1,0,1 at 4 cycles each; tx=1 for 4 cycles; busy=0 after edge k+41.
REQ-033 Write 6 bytes in 6 consecutive cycles -> bytes 1..5 accepted, byte 6 dropped with ovf=1; 5 frames transmitted in order with no gaps (200 cycles); status reads 0x4 when done.
REQ-034 Write to 0x400010 after the overflow case -> ovf=0; status reads 0x0.
REQ-035 Assert resetn=0 during DATA bit 3 -> tx=1 in the same cycle; after release, status=0 and no further frame is sent.
REQ-036 Fill the FIFO, then write on the same cycle as the STOP-end pop -> write dropped, ovf=1, count stays DEPTH-1 after the pop.
